instr_fetch: RTL

Instruction fetch stage sitting directly upstream of the main/ALU control decoder in the RV32I core. Holds the PC and issues one word-aligned request at a time to instruction memory over a valid/ready request channel with a variable-latency response. Presents a stable instruction word to the decoder (op = instr[6:0], func3 = instr[14:12], func7 = instr[31:25]). Computes the next PC from the decoder's pc_source and the datapath's branch/jump target.

---
 rtl/instr_fetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: holds the PC, issues one imem request at a time
// and presents a stable instruction word to the decoder until commit.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            commit,
  input  logic            pc_source,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_fault,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            misaligned;
  logic            do_commit;
  logic            do_capture;

  assign pc_plus4      = pc + XLEN'(4);
  assign imem_req_addr = pc;

  always_comb begin
    pc_nxt     = pc_source ? pc_target : pc_plus4;
    misaligned = |pc_nxt[1:0];
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    do_commit      = 1'b0;
    do_capture     = 1'b0;
    unique case (state)
      S_REQ: begin
        // Suppressed while rst is held so nothing is issued during reset
        imem_req_valid = ~rst;
        if (imem_req_ready && !rst)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          do_capture = 1'b1;
          state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (commit) begin
          do_commit = 1'b1;
          state_nxt = misaligned ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= XLEN'(RESET_PC);
      instr       <= NOP;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_nxt;
      if (do_capture) begin
        instr       <= imem_rsp_data;
        instr_valid <= 1'b1;
      end
      if (do_commit) begin
        instr_valid <= 1'b0;
        fetch_count <= fetch_count + 32'd1;
        // A misaligned target leaves pc pointing at the offending instruction
        if (misaligned)
          fetch_fault <= 1'b1;
        else
          pc <= pc_nxt;
      end
    end
  end

endmodule
